sram_1rw_req_ctrl: RTL and testbench
====================================

Name: sram_1rw_req_ctrl

Overview:
- Requester/initiator for the single-port 1RW SRAM wrapper: drives CE/A/RDWEN/BW/DIN and consumes DOUT.
- Front side is a valid/ready request channel plus a valid/ready read-response channel with a credit-checked response FIFO, so consumer backpressure never loses SRAM read data.
- After reset it zero-fills the whole array with a write sweep before accepting traffic.
- Sits between a cache/buffer client and one bram_1rw_wrapper instance.

Parameters:
- DEPTH, 64, number of SRAM words.
- ADDR_WIDTH, 6, address width; DEPTH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- BITMASK_WIDTH, 4, byte-lane write mask width; DATA_WIDTH % BITMASK_WIDTH == 0.
- RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 or more sustains one read per cycle.

Ports:
- MEMCLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request accepted when req_val & req_rdy.
- req_rdwen  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_WIDTH  word address.
- req_bw  in  BITMASK_WIDTH  write lane mask; ignored for reads.
- req_din  in  DATA_WIDTH  write data.
- rsp_val  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_dout  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  high once the zero-fill completes.
- mem_ce  out  1  SRAM chip enable.
- mem_a  out  ADDR_WIDTH  SRAM address.
- mem_rdwen  out  1  SRAM read/write select.
- mem_bw  out  BITMASK_WIDTH  SRAM write mask.
- mem_din  out  DATA_WIDTH  SRAM write data.
- mem_dout  in  DATA_WIDTH  SRAM read data; valid the cycle after a read CE.

Behaviour:
- Single clock MEMCLK; reset is synchronous and active-high on RESET; all state updates on posedge MEMCLK.
- Reset values:
  - FSM = INIT, sweep addr = 0, inflight = 0, FIFO empty.
  - req_rdy = 0, rsp_val = 0, init_done = 0.
  - mem_ce = 0, mem_rdwen = 1, mem_bw = 0, mem_din = 0, mem_a = 0.
- FSM states: INIT, RUN.
- INIT (reset released):
  - Each cycle drives mem_ce=1, mem_rdwen=0, mem_bw=all-ones, mem_din=0, mem_a=sweep addr.
  - Sweep addr increments; after writing DEPTH-1, go to RUN.
  - Sweep takes exactly DEPTH cycles; init_done rises in the first RUN cycle.
  - req_rdy=0 throughout INIT.
  - RESET asserted mid-sweep restarts the sweep from address 0.
- RUN: mem_* are combinational from the request. mem_ce = req_val & req_rdy; mem_a/mem_rdwen/mem_bw/mem_din = req_*. mem_ce=0 when nothing is accepted.
- Writes: req_rdy=1 in RUN regardless of FIFO state. No response is generated. BW is passed through unchanged; BW=0 is a legal no-op write.
- Reads:
  - req_rdy = (occ + inflight < RSP_DEPTH), evaluated on registered state only. There is no combinational path from rsp_rdy to req_rdy.
  - For a write request req_rdy ignores the credit check. req_rdy therefore depends on req_rdwen; this is documented and intended.
- Read latency:
  - Read accepted in cycle N: SRAM captures at end of N, mem_dout is sampled in N+1 and pushed at end of N+1.
  - rsp_val is high in N+2 at the earliest.
  - inflight = registered copy of (read accepted last cycle).
- Response FIFO:
  - Output registered; rsp_dout = head entry.
  - Push and pop in the same cycle are allowed.
  - The credit rule guarantees no overflow. An overflow attempt fires an assertion in simulation.
- Ordering: responses are returned strictly in request order. A write to A in cycle N followed by a read of A in cycle N+1 returns the new data, since the SRAM commits the write at end of N.
- Reset mid-operation: FIFO contents and inflight data are discarded; no stale rsp_val after reset.

Decomposition:
- Package sram_ctrl_pkg: FSM state enum {INIT, RUN}; localparam for the FIFO pointer width, $clog2(RSP_DEPTH); a lane-mask all-ones helper.
- Sub-module sram_rsp_fifo: synchronous FIFO with parameters DATA_WIDTH and RSP_DEPTH, registered head, outputs occ/full/empty.
- The controller holds the FSM, sweep counter, inflight flag and credit logic.

Test Plan:
- Reset with DEPTH=64, then release → exactly 64 CE-write cycles at addresses 0..63 with BW=4'hF and DIN=0; init_done=1 in cycle 65. Reading address 17 afterwards returns 0.
- Write A=5, D=32'hDEADBEEF, BW=4'b0101, then read A=5 → rsp_dout=32'h00AD00EF, and rsp_val asserts exactly 2 cycles after the read is accepted.
- Write A=9 then read A=9 on the next cycle → read returns the just-written data.
- rsp_rdy=1, back-to-back reads of addresses 0..15 (each preloaded with value = addr) → one read accepted per cycle, 16 responses in order, values 0..15.
- rsp_rdy=0 with reads streamed → exactly 3 reads accepted, req_rdy=0 while a write is still accepted. Raising rsp_rdy drains 3 responses in order with no loss or duplication.
- RESET asserted at sweep address 30 → sweep restarts at address 0. RESET asserted with 2 FIFO entries held → rsp_val=0 the next cycle, and no stale data appears after the new init completes.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and sizing helpers for the 1RW SRAM requester
package sram_ctrl_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int MAX_BW = 64;
  localparam int RSP_DEPTH_DEF = 3;
  localparam int RSP_PTR_W_DEF = $clog2(RSP_DEPTH_DEF);
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
  function automatic logic [MAX_BW-1:0] lane_ones(input int w);
    return (w >= MAX_BW) ? '1 : (MAX_BW'(1) << w) - MAX_BW'(1);
  endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small synchronous response FIFO with registered head and occupancy
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 3,
  localparam int PW = ptr_w(RSP_DEPTH),
  localparam int CW = ptr_w(RSP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [CW-1:0]         o_occ,
  output logic                  o_full,
  output logic                  o_empty
);
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_occ;
  logic w_pop;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rp];
  assign o_occ   = r_occ;
  assign o_empty = (r_occ == '0);
  assign o_full  = (r_occ == CW'(RSP_DEPTH));
  // storage needs no reset; only pointers and occupancy define validity
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  // pointer and occupancy bookkeeping, wrapping at RSP_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) r_wp <= (r_wp == PW'(RSP_DEPTH - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop) r_rp <= (r_rp == PW'(RSP_DEPTH - 1)) ? '0 : r_rp + PW'(1);
      r_occ <= r_occ + CW'(i_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl: zero-fills a 1RW SRAM after reset, then issues credit-checked requests
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int BITMASK_WIDTH = 4,
  parameter int RSP_DEPTH     = 3
) (
  input  logic                     MEMCLK,
  input  logic                     RESET,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_rdwen,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [BITMASK_WIDTH-1:0] req_bw,
  input  logic [DATA_WIDTH-1:0]    req_din,
  output logic                     rsp_val,
  input  logic                     rsp_rdy,
  output logic [DATA_WIDTH-1:0]    rsp_dout,
  output logic                     init_done,
  output logic                     mem_ce,
  output logic [ADDR_WIDTH-1:0]    mem_a,
  output logic                     mem_rdwen,
  output logic [BITMASK_WIDTH-1:0] mem_bw,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);
  localparam int CW = ptr_w(RSP_DEPTH + 1);
  state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic r_inflight, w_credit, w_rd_acc, w_pop, w_full, w_empty;
  logic [CW-1:0] w_occ;
  assign w_credit  = (int'(w_occ) + int'(r_inflight)) < RSP_DEPTH;
  assign w_rd_acc  = mem_ce && mem_rdwen;
  assign rsp_val   = !w_empty;
  assign w_pop     = rsp_val && rsp_rdy;
  assign init_done = (r_state == RUN);
  // state, sweep address and in-flight read flag
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_state    <= INIT;
      r_sweep    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sweep    <= (r_state == INIT) ? r_sweep + ADDR_WIDTH'(1) : r_sweep;
      r_inflight <= w_rd_acc;
    end
  end
  // next state and SRAM drive; reset forces the idle pins so no write leaks during reset
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    mem_ce      = 1'b0;
    mem_a       = '0;
    mem_rdwen   = 1'b1;
    mem_bw      = '0;
    mem_din     = '0;
    if (!RESET && r_state == INIT) begin
      mem_ce      = 1'b1;
      mem_rdwen   = 1'b0;
      mem_bw      = BITMASK_WIDTH'(lane_ones(BITMASK_WIDTH));
      mem_a       = r_sweep;
      w_state_nxt = (r_sweep == ADDR_WIDTH'(DEPTH - 1)) ? RUN : INIT;
    end else if (!RESET) begin
      req_rdy   = !req_rdwen || w_credit;
      mem_ce    = req_val && req_rdy;
      mem_a     = req_addr;
      mem_rdwen = req_rdwen;
      mem_bw    = req_bw;
      mem_din   = req_din;
    end
  end
  sram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)) u_fifo (
    .clk    (MEMCLK),
    .rst    (RESET),
    .i_push (r_inflight),
    .i_din  (mem_dout),
    .i_pop  (w_pop),
    .o_dout (rsp_dout),
    .o_occ  (w_occ),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  a_no_overflow: assert property (@(posedge MEMCLK) disable iff (RESET) !(r_inflight && w_full && !w_pop));
endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb_sram_1rw_req_ctrl: directed checks of sweep, latency, ordering, backpressure and reset flush
module tb_sram_1rw_req_ctrl;
  logic MEMCLK = 1'b0;
  logic RESET = 1'b1;
  logic req_val = 1'b0, req_rdy, req_rdwen = 1'b1;
  logic [5:0] req_addr = '0;
  logic [3:0] req_bw = '0;
  logic [31:0] req_din = '0;
  logic rsp_val, rsp_rdy = 1'b1;
  logic [31:0] rsp_dout;
  logic init_done, mem_ce, mem_rdwen;
  logic [5:0] mem_a;
  logic [3:0] mem_bw;
  logic [31:0] mem_din, mem_dout;
  logic [31:0] sram [64];
  int n_chk = 0, n_fail = 0;
  always #5 MEMCLK = ~MEMCLK;
  sram_1rw_req_ctrl dut (
    .MEMCLK(MEMCLK), .RESET(RESET),
    .req_val(req_val), .req_rdy(req_rdy), .req_rdwen(req_rdwen),
    .req_addr(req_addr), .req_bw(req_bw), .req_din(req_din),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout),
    .init_done(init_done),
    .mem_ce(mem_ce), .mem_a(mem_a), .mem_rdwen(mem_rdwen),
    .mem_bw(mem_bw), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  always @(posedge MEMCLK)
    if (mem_ce) begin
      if (mem_rdwen) mem_dout <= sram[mem_a];
      else for (int l = 0; l < 4; l++) if (mem_bw[l]) sram[mem_a][8*l +: 8] <= mem_din[8*l +: 8];
    end
  task automatic step();
    @(posedge MEMCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] bw);
    req_val = 1'b1; req_rdwen = 1'b0; req_addr = a; req_din = d; req_bw = bw;
    @(negedge MEMCLK);
    chk("wr_rdy", req_rdy, 1);
    step();
    req_val = 1'b0; req_rdwen = 1'b1;
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    req_val = 1'b1; req_rdwen = 1'b1; req_addr = a;
    @(negedge MEMCLK);
    chk({tag, "_rdy"}, req_rdy, 1);
    step();
    req_val = 1'b0;
    @(negedge MEMCLK);
    chk({tag, "_lat1"}, rsp_val, 0);
    step();
    @(negedge MEMCLK);
    chk({tag, "_lat2"}, rsp_val, 1);
    chk({tag, "_data"}, rsp_dout, exp);
    step();
  endtask
  task automatic wait_init(input string tag);
    int k = 0;
    @(negedge MEMCLK);
    while (!init_done && k < 200) begin
      step();
      @(negedge MEMCLK);
      k++;
    end
    chk(tag, init_done, 1);
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  initial begin
    int bad, acc, nrx, cnt;
    step(); step();
    @(negedge MEMCLK);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_done", init_done, 0);
    chk("rst_ce", mem_ce, 0);
    chk("rst_rdwen", mem_rdwen, 1);
    chk("rst_bw", mem_bw, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_a", mem_a, 0);
    step();
    RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge MEMCLK);
      if (!(mem_ce && !mem_rdwen && mem_a == 6'(i) && mem_bw == 4'hF && mem_din == 0 && !req_rdy && !init_done)) bad++;
      step();
    end
    chk("sweep_bad_cycles", bad, 0);
    @(negedge MEMCLK);
    chk("done_cycle65", init_done, 1);
    chk("idle_ce", mem_ce, 0);
    step();
    rd(6'd17, 32'h0, "zero17");
    wr(6'd5, 32'hDEADBEEF, 4'b0101);
    rd(6'd5, 32'h00AD00EF, "bw5");
    wr(6'd9, 32'h12345678, 4'hF);
    rd(6'd9, 32'h12345678, "wr_rd9");
    for (int i = 0; i < 16; i++) wr(6'(i), 32'(i), 4'hF);
    acc = 0; nrx = 0;
    for (int c = 0; c < 20; c++) begin
      req_val = (c < 16); req_rdwen = 1'b1; req_addr = 6'(c);
      @(negedge MEMCLK);
      if (c < 16 && req_rdy) acc++;
      if (rsp_val) begin
        chk("b2b_data", rsp_dout, 32'(nrx));
        nrx++;
      end
      step();
    end
    req_val = 1'b0;
    chk("b2b_accepted", acc, 16);
    chk("b2b_responses", nrx, 16);
    rsp_rdy = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_val = 1'b1; req_rdwen = 1'b1; req_addr = 6'(acc);
      @(negedge MEMCLK);
      if (req_rdy) acc++;
      step();
    end
    chk("bp_accepted", acc, 3);
    @(negedge MEMCLK);
    chk("bp_rd_rdy", req_rdy, 0);
    #1 req_rdwen = 1'b0; req_addr = 6'd40; req_din = 32'h0000CAFE; req_bw = 4'hF;
    #1 chk("bp_wr_rdy", req_rdy, 1);
    chk("bp_wr_ce", mem_ce, 1);
    step();
    req_val = 1'b0; req_rdwen = 1'b1;
    rsp_rdy = 1'b1; nrx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge MEMCLK);
      if (rsp_val) begin
        chk("bp_data", rsp_dout, 32'(nrx));
        nrx++;
      end
      step();
    end
    chk("bp_responses", nrx, 3);
    wr(6'd20, 32'hAAAA0001, 4'hF);
    wr(6'd21, 32'hAAAA0002, 4'hF);
    rsp_rdy = 1'b0;
    req_val = 1'b1; req_rdwen = 1'b1; req_addr = 6'd20;
    step();
    req_addr = 6'd21;
    step();
    req_val = 1'b0;
    step();
    @(negedge MEMCLK);
    chk("hold_val", rsp_val, 1);
    chk("hold_head", rsp_dout, 32'hAAAA0001);
    RESET = 1'b1;
    step();
    @(negedge MEMCLK);
    chk("rst_flush_val", rsp_val, 0);
    step();
    RESET = 1'b0;
    for (int i = 0; i < 30; i++) step();
    @(negedge MEMCLK);
    chk("sweep_at30", mem_a, 30);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    @(negedge MEMCLK);
    chk("sweep_restart_a", mem_a, 0);
    chk("sweep_restart_ce", mem_ce, 1);
    step();
    wait_init("reinit_done");
    rsp_rdy = 1'b1; cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge MEMCLK);
      if (rsp_val) cnt++;
      step();
    end
    chk("no_stale_rsp", cnt, 0);
    rd(6'd20, 32'h0, "post_rst20");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
